// File: rtl/lstm_input_framer_if.sv
// Handshake bundle between the sample source, the framer and the lstm.
//   slave  : framer side (takes samples, presents frames)
//   master : environment side (drives samples, consumes frames)
// Fill side : i_valid, i_data, o_ready, i_flush, o_level
// Frame side: o_x, o_valid, i_ready
interface lstm_input_framer_if #(
  parameter int WIDTH = 32,
  parameter int NUM   = 35
);
  logic                   i_valid;
  logic [WIDTH-1:0]       i_data;
  logic                   o_ready;
  logic                   i_flush;
  logic [NUM*WIDTH-1:0]   o_x;
  logic                   o_valid;
  logic                   i_ready;
  logic [7:0]             o_level;

  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_ready, o_x, o_valid, o_level
  );

  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_ready, o_x, o_valid, o_level
  );
endinterface

// File: rtl/lstm_input_framer.sv
// Serial-to-parallel framer feeding the lstm i_x port. Samples are written
// into a NUM-word fill buffer; a complete buffer moves into the hold register
// (o_x) as soon as that register is free, so the next frame can stream in
// while the current one waits for the lstm.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - lstm_input_framer_if.slave (sample in, frame out, flush, level)
module lstm_input_framer #(
  parameter int WIDTH = 32,
  parameter int NUM   = 35
) (
  input  logic                clk,
  input  logic                rst,
  lstm_input_framer_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(NUM - 1);
  localparam logic [7:0] CNT_FULL = 8'(NUM);

  logic [7:0]                  cnt;
  logic [NUM-1:0][WIDTH-1:0]   fill_q;
  logic [NUM-1:0][WIDTH-1:0]   frame_d;
  logic [NUM-1:0][WIDTH-1:0]   hold_q;
  logic                        hold_vld;
  logic                        full, accept, hold_free, xfer;

  assign full      = (cnt == CNT_FULL);
  assign bus.o_ready = !full && !bus.i_flush;
  assign accept    = bus.i_valid && bus.o_ready;
  assign hold_free = !hold_vld || bus.i_ready;
  // Completion is either the last sample arriving now or a buffer already
  // FULL from an earlier edge; flush wins over both.
  assign xfer      = !bus.i_flush && hold_free &&
                     (full || (accept && cnt == CNT_LAST));

  // Fill buffer with this cycle's sample merged in, so a transfer on the
  // accepting edge carries the final word without an extra cycle.
  genvar k;
  generate
    for (k = 0; k < NUM; k++) begin : g_slot
      assign frame_d[k] = (accept && cnt == 8'(k)) ? bus.i_data : fill_q[k];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      fill_q   <= '0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else begin
      fill_q <= frame_d;

      if (bus.i_flush || xfer) cnt <= '0;
      else if (accept)         cnt <= cnt + 8'd1;

      if (xfer) begin
        hold_q   <= frame_d;
        hold_vld <= 1'b1;
      end else if (bus.i_ready) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign bus.o_x     = hold_q;
  assign bus.o_valid = hold_vld;
  assign bus.o_level = cnt;

endmodule

// File: tb/tb_lstm_input_framer.sv
module tb_lstm_input_framer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lstm_input_framer_if #(.WIDTH(W), .NUM(35)) b35 ();
  lstm_input_framer_if #(.WIDTH(W), .NUM(4))  b4  ();

  lstm_input_framer #(.WIDTH(W), .NUM(35)) u_dut35 (.clk(clk), .rst(rst), .bus(b35.slave));
  lstm_input_framer #(.WIDTH(W), .NUM(4))  u_dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] f4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Drive NUM=4 inputs at the falling edge, settle, leave the caller to check.
  task automatic step4(input bit v, input logic [31:0] d, input bit fl, input bit rdy);
    @(negedge clk);
    b4.i_valid = v; b4.i_data = d; b4.i_flush = fl; b4.i_ready = rdy;
    #1;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          fl;
    bit          rdy;
    bit          e_rdy;
    bit          e_vld;
    logic [7:0]  e_lvl;
    logic [127:0] e_x;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [31:0] d, bit fl, bit rdy,
                              bit er, bit ev, logic [7:0] el, logic [127:0] ex);
    vec_t t;
    t.v = v; t.d = d; t.fl = fl; t.rdy = rdy;
    t.e_rdy = er; t.e_vld = ev; t.e_lvl = el; t.e_x = ex;
    return t;
  endfunction

  // Reference model for NUM=4: sample queue plus a held frame.
  logic [31:0]       mq[$];
  logic [3:0][31:0]  mh;
  bit                mvld;

  logic [35*32-1:0] fr1, fr2;
  int pulse_at[$];

  initial begin
    logic [127:0] x4321, x8765, xc, xdcba;
    b4.i_valid = 0; b4.i_data = '0; b4.i_flush = 0; b4.i_ready = 0;
    b35.i_valid = 0; b35.i_data = '0; b35.i_flush = 0; b35.i_ready = 1;

    // Reset state
    #2;
    chk("rst_vld", b4.o_valid, 0);
    chk("rst_x", b4.o_x, 0);
    chk("rst_lvl", b4.o_level, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rdy", b4.o_ready, 1);

    // Continuous stream into NUM=35 with i_ready high
    for (int i = 0; i <= 70; i++) begin
      @(negedge clk);
      b35.i_valid = (i < 70);
      b35.i_data  = 32'(i + 1);
      #1;
      if (i < 70) chk("s35_rdy", b35.o_ready, 1);
      if (b35.o_valid) begin
        pulse_at.push_back(i);
        if (pulse_at.size() == 1) fr1 = b35.o_x;
        if (pulse_at.size() == 2) fr2 = b35.o_x;
      end
    end
    b35.i_valid = 0;
    chk("s35_npulse", pulse_at.size(), 2);
    if (pulse_at.size() == 2) begin
      chk("s35_p1_cycle", pulse_at[0], 35);
      chk("s35_p2_cycle", pulse_at[1], 70);
      chk("s35_f1_lo", fr1[31:0], 32'h1);
      chk("s35_f1_hi", fr1[1119:1088], 32'h23);
      chk("s35_f2_lo", fr2[31:0], 32'h24);
      for (int k = 0; k < 35; k++) begin
        chk("s35_f1_word", fr1[k*32 +: 32], 32'(k + 1));
        chk("s35_f2_word", fr2[k*32 +: 32], 32'(k + 36));
      end
    end

    // Table: backpressure, consume on completion, gapped input (NUM=4)
    x4321 = f4(1, 2, 3, 4);
    x8765 = f4(5, 6, 7, 8);
    xc    = f4(9, 10, 11, 12);
    xdcba = f4(32'hA, 32'hB, 32'hC, 32'hD);
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 3, 0, 0, 1, 0, 2, 0));
    tbl.push_back(mk(1, 4, 0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(1, 5, 0, 0, 1, 1, 0, x4321));
    tbl.push_back(mk(1, 6, 0, 0, 1, 1, 1, x4321));
    tbl.push_back(mk(1, 7, 0, 0, 1, 1, 2, x4321));
    tbl.push_back(mk(1, 8, 0, 0, 1, 1, 3, x4321));
    tbl.push_back(mk(1, 9, 0, 0, 0, 1, 4, x4321));
    tbl.push_back(mk(1, 9, 0, 1, 0, 1, 4, x4321));
    tbl.push_back(mk(1, 9, 0, 0, 1, 1, 0, x8765));
    tbl.push_back(mk(1, 10, 0, 0, 1, 1, 1, x8765));
    tbl.push_back(mk(1, 11, 0, 0, 1, 1, 2, x8765));
    tbl.push_back(mk(1, 12, 0, 1, 1, 1, 3, x8765));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, xc));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, xc));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, xc));
    tbl.push_back(mk(1, 32'hA, 0, 1, 1, 0, 0, xc));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, xc));
    tbl.push_back(mk(1, 32'hB, 0, 1, 1, 0, 1, xc));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2, xc));
    tbl.push_back(mk(1, 32'hC, 0, 1, 1, 0, 2, xc));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 3, xc));
    tbl.push_back(mk(1, 32'hD, 0, 1, 1, 0, 3, xc));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, xdcba));
    foreach (tbl[i]) begin
      step4(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_rdy", i), b4.o_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_vld", i), b4.o_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_lvl", i), b4.o_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_x", i), b4.o_x, tbl[i].e_x);
    end
    // Last row consumed the frame at its edge; state: hold empty, level 0.

    // Flush with a held frame
    for (int i = 0; i < 4; i++) step4(1, 32'h11 + i, 0, 0);
    step4(1, 32'h21, 0, 0);
    chk("fl_held_vld", b4.o_valid, 1);
    chk("fl_held_x", b4.o_x, f4(32'h11, 32'h12, 32'h13, 32'h14));
    step4(1, 32'h22, 0, 0);
    step4(1, 32'hFF, 1, 0);
    chk("fl_rdy_low", b4.o_ready, 0);
    chk("fl_lvl_pre", b4.o_level, 2);
    step4(0, 0, 0, 0);
    chk("fl_lvl0", b4.o_level, 0);
    chk("fl_vld_kept", b4.o_valid, 1);
    chk("fl_x_kept", b4.o_x, f4(32'h11, 32'h12, 32'h13, 32'h14));
    for (int i = 0; i < 4; i++) step4(1, 32'h31 + i, 0, 0);
    step4(0, 0, 0, 1);
    chk("fl_full_lvl", b4.o_level, 4);
    chk("fl_full_x", b4.o_x, f4(32'h11, 32'h12, 32'h13, 32'h14));
    step4(0, 0, 0, 0);
    chk("fl_new_x", b4.o_x, f4(32'h31, 32'h32, 32'h33, 32'h34));
    chk("fl_new_vld", b4.o_valid, 1);
    chk("fl_new_lvl", b4.o_level, 0);

    // Reset mid-operation: held frame valid, 3 samples filled
    for (int i = 0; i < 3; i++) step4(1, 32'h41 + i, 0, 0);
    step4(0, 0, 0, 0);
    chk("mr_pre_lvl", b4.o_level, 3);
    chk("mr_pre_vld", b4.o_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("mr_vld", b4.o_valid, 0);
    chk("mr_x", b4.o_x, 0);
    chk("mr_lvl", b4.o_level, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step4(1, 32'h51 + i, 0, 1);
    step4(0, 0, 0, 1);
    chk("mr_frame_vld", b4.o_valid, 1);
    chk("mr_frame_x", b4.o_x, f4(32'h51, 32'h52, 32'h53, 32'h54));

    // Randomized traffic against the queue model, from a fresh reset
    step4(0, 0, 0, 0);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    mq.delete(); mh = '0; mvld = 0;
    for (int c = 0; c < 600; c++) begin
      bit v, fl, r, erdy, free;
      logic [31:0] d;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      step4(v, d, fl, r);
      erdy = (mq.size() < 4) && !fl;
      chk("rnd_rdy", b4.o_ready, erdy);
      chk("rnd_vld", b4.o_valid, mvld);
      chk("rnd_lvl", b4.o_level, mq.size());
      chk("rnd_x", b4.o_x, mh);
      free = !mvld || r;
      if (mvld && r) mvld = 0;
      if (fl) mq.delete();
      else begin
        if (v && erdy) mq.push_back(d);
        if (mq.size() == 4 && free) begin
          for (int k = 0; k < 4; k++) mh[k] = mq[k];
          mq.delete();
          mvld = 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
